// File: rtl/arbitro_rr_fifos.sv
// arbitro_rr_fifos: round-robin drain of 8 input VC FIFOs into one egress
// FIFO, one word per cycle, gated by link ACTIVE and hysteresis backpressure.
// Ports: clk, reset (async, active-low), active, umbral_L/umbral_H (resume /
// pause thresholds), empty[8], data_in[8*DATA_W], down_count -> pop[8],
// push_out, data_out, grant_idx, pause, state (IDLE=0, ARB=1, PAUSE=2).
// Build option: define ARB_PRIO0_EN for strict priority of FIFO 0.
module arbitro_rr_fifos #(
  parameter int DATA_W       = 10,
  parameter int UMBRALES_L_H = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [UMBRALES_L_H-1:0] umbral_L,
  input  logic [UMBRALES_L_H-1:0] umbral_H,
  input  logic [7:0]              empty,
  input  logic [8*DATA_W-1:0]     data_in,
  input  logic [UMBRALES_L_H-1:0] down_count,
  output logic [7:0]              pop,
  output logic                    push_out,
  output logic [DATA_W-1:0]       data_out,
  output logic [2:0]              grant_idx,
  output logic                    pause,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    PAUSE = 2'd2
  } st_t;

  st_t        st_q;
  logic [2:0] sel;
  logic       hit;
  logic       go;
  logic       fire;
  logic       all_empty;
  logic [2:0] idx_q;
  logic       vld_q;
  int         t;

  assign all_empty = (empty == 8'hFF);
  assign go        = reset && active && !pause && (st_q == ARB);
  assign fire      = go && hit;
  assign state     = st_q;
  assign push_out  = vld_q;

`ifdef ARB_PRIO0_EN
  // rr_q only tracks grants to 1..7; FIFO 0 grants bypass it.
  logic [2:0] rr_q;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    t   = 0;
    if (!empty[0]) begin
      sel = 3'd0;
      hit = 1'b1;
    end else begin
      for (int k = 1; k <= 7; k++) begin
        t = (int'(rr_q) + k - 1) % 7 + 1;
        if (!hit && !empty[3'(t)]) begin
          sel = 3'(t);
          hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 3'd7;
    end else if (fire && sel != 3'd0) begin
      rr_q <= sel;
    end
  end
`else
  // Scan starts one past the last grant; k=8 lands back on grant_idx.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    t   = 0;
    for (int k = 1; k <= 8; k++) begin
      t = int'(grant_idx) + k;
      if (!hit && !empty[3'(t)]) begin
        sel = 3'(t);
        hit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    pop = '0;
    if (fire) pop[sel] = 1'b1;
  end

  // Read data shows up the cycle after the pop, so the mux follows the
  // registered index rather than the live one.
  always_comb begin
    data_out = '0;
    if (vld_q) data_out = data_in[int'(idx_q)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_idx <= 3'd7;
      idx_q     <= '0;
      vld_q     <= 1'b0;
    end else begin
      vld_q <= fire;
      if (fire) begin
        grant_idx <= sel;
        idx_q     <= sel;
      end
    end
  end

  // Set wins over clear when thresholds overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause <= 1'b0;
    end else if (down_count >= umbral_H) begin
      pause <= 1'b1;
    end else if (down_count <= umbral_L) begin
      pause <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (active && !all_empty) st_q <= ARB;
        end
        ARB: begin
          if (!active || all_empty) st_q <= IDLE;
          else if (pause)           st_q <= PAUSE;
        end
        PAUSE: begin
          if (!active)     st_q <= IDLE;
          else if (!pause) st_q <= ARB;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr_fifos.sv
// tb_arbitro_rr_fifos: directed bench for arbitro_rr_fifos with a small
// behavioural model of the 8 input FIFOs.
module tb_arbitro_rr_fifos;

  localparam int DW = 10;
  localparam int UW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          active = 1'b0;
  logic [UW-1:0] umbral_L = 8'd2;
  logic [UW-1:0] umbral_H = 8'd6;
  logic [UW-1:0] down_count = '0;
  logic [7:0]    empty;
  logic [8*DW-1:0] data_in;
  logic [7:0]    pop;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [2:0]    grant_idx;
  logic          pause;
  logic [1:0]    state;

  int n_chk = 0;
  int n_err = 0;

  arbitro_rr_fifos #(.DATA_W(DW), .UMBRALES_L_H(UW)) dut (
    .clk(clk), .reset(reset), .active(active),
    .umbral_L(umbral_L), .umbral_H(umbral_H),
    .empty(empty), .data_in(data_in), .down_count(down_count),
    .pop(pop), .push_out(push_out), .data_out(data_out),
    .grant_idx(grant_idx), .pause(pause), .state(state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [8][32];
  logic [DW-1:0] rdata [8];
  int wr [8];
  int rd [8];
  logic clr = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (clr) begin
        rd[i] <= 0;
      end else if (pop[i]) begin
        rdata[i] <= mem[i][rd[i] % 32];
        rd[i]    <= rd[i] + 1;
      end
    end
  end

  always_comb begin
    empty   = '0;
    data_in = '0;
    for (int i = 0; i < 8; i++) begin
      empty[i] = (rd[i] == wr[i]);
      data_in[i*DW +: DW] = rdata[i];
    end
  end

  function automatic logic [DW-1:0] w(int i, int k);
    return DW'(i * 32 + k + 1);
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(int i, int n);
    for (int k = 0; k < n; k++) begin
      mem[i][wr[i] % 32] = w(i, wr[i]);
      wr[i] = wr[i] + 1;
    end
  endtask

  task automatic start();
    reset = 1'b0;
    active = 1'b0;
    down_count = '0;
    clr = 1'b1;
    for (int i = 0; i < 8; i++) wr[i] = 0;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cyc(string tag, logic [7:0] ep, logic eq,
                     logic [DW-1:0] ed);
    @(negedge clk);
    check({tag, ".pop"}, pop, ep);
    check({tag, ".push"}, push_out, eq);
    if (eq) check({tag, ".data"}, data_out, ed);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) wr[i] = 0;
    #12;
    check("rst.state", state, 0);
    check("rst.pause", pause, 0);
    check("rst.push", push_out, 0);
    check("rst.pop", pop, 0);
    check("rst.grant", grant_idx, 7);
    check("rst.data", data_out, 0);

    // single words in 0,3,5
    start();
    load(0, 1); load(3, 1); load(5, 1);
    active = 1'b1;
    release_rst();
    cyc("t1c1", 8'h01, 1'b0, '0);
    check("t1c1.state", state, 1);
    cyc("t1c2", 8'h08, 1'b1, w(0, 0));
    check("t1c2.grant", grant_idx, 0);
    cyc("t1c3", 8'h20, 1'b1, w(3, 0));
    check("t1c3.grant", grant_idx, 3);
    cyc("t1c4", 8'h00, 1'b1, w(5, 0));
    check("t1c4.grant", grant_idx, 5);
    cyc("t1c5", 8'h00, 1'b0, '0);
    check("t1c5.state", state, 0);

`ifndef ARB_PRIO0_EN
    // two words everywhere: 0..7, 0..7 with wrap
    start();
    for (int i = 0; i < 8; i++) load(i, 2);
    active = 1'b1;
    release_rst();
    for (int n = 1; n <= 18; n++) begin
      logic [7:0] ep;
      logic       eq;
      int         g;
      ep = (n <= 16) ? 8'(1 << ((n - 1) % 8)) : 8'h00;
      eq = (n >= 2 && n <= 17);
      g  = (n == 1) ? 7 : (n <= 17 ? (n - 2) % 8 : 7);
      cyc($sformatf("t2n%0d", n), ep, eq,
          w((n - 2 + 8) % 8, (n - 2) / 8));
      check($sformatf("t2n%0d.grant", n), grant_idx, g);
    end
    check("t2.state", state, 0);
`endif

    // hysteresis
    start();
    load(1, 12);
    active = 1'b1;
    release_rst();
    for (int k = 1; k <= 7; k++) begin
      cyc($sformatf("t3k%0d", k), 8'h02, k >= 2, w(1, k - 2));
      check($sformatf("t3k%0d.pause", k), pause, 0);
      down_count = UW'(k - 1);
    end
    cyc("t3k8", 8'h00, 1'b1, w(1, 6));
    check("t3k8.pause", pause, 1);
    check("t3k8.state", state, 1);
    cyc("t3k9", 8'h00, 1'b0, '0);
    check("t3k9.state", state, 2);
    down_count = 8'd3;
    cyc("t3k10", 8'h00, 1'b0, '0);
    check("t3k10.pause", pause, 1);
    down_count = 8'd2;
    cyc("t3k11", 8'h00, 1'b0, '0);
    check("t3k11.pause", pause, 0);
    check("t3k11.state", state, 2);
    cyc("t3k12", 8'h02, 1'b0, '0);
    check("t3k12.state", state, 1);
    cyc("t3k13", 8'h02, 1'b1, w(1, 7));

    // active drops mid-stream
    start();
    load(2, 4);
    active = 1'b1;
    release_rst();
    cyc("t4c1", 8'h04, 1'b0, '0);
    cyc("t4c2", 8'h04, 1'b1, w(2, 0));
    active = 1'b0;
    #1;
    check("t4drop.pop", pop, 0);
    check("t4drop.push", push_out, 1);
    check("t4drop.data", data_out, w(2, 0));
    cyc("t4c3", 8'h00, 1'b0, '0);
    check("t4c3.state", state, 0);
    check("t4c3.grant", grant_idx, 2);
    cyc("t4c4", 8'h00, 1'b0, '0);

    // reset mid-stream
    start();
    load(3, 4); load(6, 4);
    active = 1'b1;
    release_rst();
    cyc("t5c1", 8'h08, 1'b0, '0);
    cyc("t5c2", 8'h40, 1'b1, w(3, 0));
    down_count = 8'd7;
    cyc("t5c3", 8'h00, 1'b1, w(6, 0));
    check("t5c3.pause", pause, 1);
    reset = 1'b0;
    #1;
    check("t5rst.pop", pop, 0);
    check("t5rst.push", push_out, 0);
    check("t5rst.pause", pause, 0);
    check("t5rst.data", data_out, 0);
    check("t5rst.state", state, 0);
    check("t5rst.grant", grant_idx, 7);
    down_count = '0;
    load(0, 1);
    release_rst();
    cyc("t5r1", 8'h01, 1'b0, '0);
    cyc("t5r2", 8'h08, 1'b1, w(0, 0));
    check("t5r2.grant", grant_idx, 0);
    cyc("t5r3", 8'h40, 1'b1, w(3, 1));
    check("t5r3.grant", grant_idx, 3);

`ifdef ARB_PRIO0_EN
    // strict priority of FIFO 0
    start();
    load(0, 3); load(2, 2);
    active = 1'b1;
    release_rst();
    cyc("t6c1", 8'h01, 1'b0, '0);
    cyc("t6c2", 8'h01, 1'b1, w(0, 0));
    cyc("t6c3", 8'h01, 1'b1, w(0, 1));
    cyc("t6c4", 8'h04, 1'b1, w(0, 2));
    cyc("t6c5", 8'h04, 1'b1, w(2, 0));
    cyc("t6c6", 8'h00, 1'b1, w(2, 1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
